// File: rtl/hack_ram_arbiter.sv
// hack_ram_arbiter: shares the single-port hack 16K x 16 data RAM between CPU port A and DMA port B
// Ports: clock, reset_n (async active-low); a_*/b_*: req, we, addr, wdata in, gnt, rvalid, rdata out;
//   ram_load/ram_addr/ram_in drive the RAM, ram_out is its registered-address read data.
module hack_ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);
  logic [3:0] starve_cnt;
  logic b_pri;
  logic [DATA_W-1:0] a_hold, b_hold;
  always_comb begin
    b_pri = starve_cnt == 4'(STARVE_MAX);
    a_gnt = a_req & ~(b_pri & b_req);
    b_gnt = b_req & (b_pri | ~a_req);
    ram_load = a_gnt ? a_we : b_gnt & b_we;
    ram_addr = a_gnt ? a_addr : b_gnt ? b_addr : '0;
    ram_in = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    a_rdata = a_rvalid ? ram_out : a_hold;
    b_rdata = b_rvalid ? ram_out : b_hold;
  end
  // starve_cnt saturates at STARVE_MAX, which is exactly when B wins priority
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      starve_cnt <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      starve_cnt <= (b_req & ~b_gnt) ? (b_pri ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_rvalid) a_hold <= ram_out;
      if (b_rvalid) b_hold <= ram_out;
    end
endmodule

// File: tb/tb_hack_ram_arbiter.sv
// tb_hack_ram_arbiter: directed and randomized checks of hack_ram_arbiter against a behavioural model
module tb_hack_ram_arbiter;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int SM = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, ram_load;
  logic [DW-1:0] a_rdata, b_rdata, ram_in, ram_out;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram [1<<AW];
  logic [AW-1:0] ram_q;
  logic [DW-1:0] shadow [1<<AW];
  int denied;
  bit m_arv, m_brv, e_ag, e_bg, e_ld;
  logic [DW-1:0] m_ard, m_brd, e_in;
  logic [AW-1:0] e_addr;
  int checks = 0;
  int passed = 0;

  hack_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_load(ram_load), .ram_addr(ram_addr), .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clock = ~clock;

  // hack RAM: write on edge, address registered, read data one cycle later
  always @(posedge clock) begin
    if (ram_load) ram[ram_addr] <= ram_in;
    ram_q <= ram_addr;
  end
  assign ram_out = ram[ram_q];

  // grant rules: B gets priority once it has been denied STARVE_MAX cycles in a row
  function automatic void model_eval();
    if (denied >= SM) begin
      e_bg = b_req;
      e_ag = a_req && !b_req;
    end else begin
      e_ag = a_req;
      e_bg = b_req && !a_req;
    end
    e_ld = e_ag ? a_we : (e_bg && b_we);
    e_addr = e_ag ? a_addr : e_bg ? b_addr : '0;
    e_in = e_ag ? a_wdata : e_bg ? b_wdata : '0;
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset_n) begin
      model_eval();
      m_arv = e_ag && !a_we;
      if (m_arv) m_ard = shadow[a_addr];
      m_brv = e_bg && !b_we;
      if (m_brv) m_brd = shadow[b_addr];
      if (e_ag && a_we) shadow[a_addr] = a_wdata;
      if (e_bg && b_we) shadow[b_addr] = b_wdata;
      denied = (b_req && !e_bg) ? denied + 1 : 0;
    end
    #1;
  endtask

  task automatic set_a(input bit req, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input bit req, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  task automatic model_reset();
    denied = 0; m_arv = 0; m_brv = 0; m_ard = '0; m_brd = '0;
  endtask

  task automatic test_reset();
    model_reset();
    set_a(1, 1, 14'h5, 16'h7777);
    set_b(1, 1, 14'h6, 16'h8888);
    #2;
    checks++; if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== '0)
      $display("FAIL reset_resp: got %h want 0", {a_rvalid, b_rvalid, a_rdata, b_rdata}); else passed++;
    checks++; if (dut.starve_cnt !== 4'd0) $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt); else passed++;
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    @(negedge clock);
    checks++; if ({a_gnt, b_gnt, ram_load, ram_addr, ram_in} !== '0)
      $display("FAIL idle_outputs: got %h want 0", {a_gnt, b_gnt, ram_load, ram_addr, ram_in}); else passed++;
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_a_only();
    set_a(1, 1, 14'h0010, 16'h1234);
    @(negedge clock);
    checks++; if ({a_gnt, b_gnt, ram_load, ram_addr, ram_in} !== {3'b101, 14'h0010, 16'h1234})
      $display("FAIL a_write_drive: got %h want %h", {a_gnt, b_gnt, ram_load, ram_addr, ram_in}, {3'b101, 14'h0010, 16'h1234}); else passed++;
    tick();
    set_a(1, 0, 14'h0010, 16'h0);
    @(negedge clock);
    checks++; if ({a_gnt, ram_load, a_rvalid} !== 3'b100) $display("FAIL a_read_drive: got %b want 100", {a_gnt, ram_load, a_rvalid}); else passed++;
    tick();
    set_a(0, 0, '0, '0);
    @(negedge clock);
    checks++; if ({a_rvalid, b_rvalid, a_rdata} !== {2'b10, 16'h1234})
      $display("FAIL a_read_resp: got %h want %h", {a_rvalid, b_rvalid, a_rdata}, {2'b10, 16'h1234}); else passed++;
    tick();
    @(negedge clock);
    checks++; if ({a_rvalid, a_rdata} !== {1'b0, 16'h1234}) $display("FAIL a_pulse_hold: got %h want %h", {a_rvalid, a_rdata}, {1'b0, 16'h1234}); else passed++;
  endtask

  task automatic test_b_only();
    set_b(1, 1, 14'h3FFF, 16'hBEEF);
    @(negedge clock);
    checks++; if ({a_gnt, b_gnt, ram_load, ram_addr} !== {3'b011, 14'h3FFF})
      $display("FAIL b_write_drive: got %h want %h", {a_gnt, b_gnt, ram_load, ram_addr}, {3'b011, 14'h3FFF}); else passed++;
    tick();
    set_b(1, 0, 14'h3FFF, 16'h0);
    tick();
    set_b(0, 0, '0, '0);
    @(negedge clock);
    checks++; if ({b_rvalid, b_rdata, a_rvalid, a_rdata} !== {1'b1, 16'hBEEF, 1'b0, 16'h1234})
      $display("FAIL b_read_resp: got %h want %h", {b_rvalid, b_rdata, a_rvalid, a_rdata}, {1'b1, 16'hBEEF, 1'b0, 16'h1234}); else passed++;
    tick();
  endtask

  task automatic test_contention();
    for (int k = 0; k < 10; k++) begin
      set_a(1, 0, AW'(14'h100 + k), '0);
      set_b(1, 0, 14'h0200, '0);
      @(negedge clock);
      model_eval();
      checks++; if ({a_gnt, b_gnt} !== {k % 5 != 4, k % 5 == 4})
        $display("FAIL contention_gnt[%0d]: got %b want %b", k, {a_gnt, b_gnt}, {k % 5 != 4, k % 5 == 4}); else passed++;
      checks++; if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== {m_arv, m_brv, m_ard, m_brd})
        $display("FAIL contention_resp[%0d]: got %h want %h", k, {a_rvalid, b_rvalid, a_rdata, b_rdata}, {m_arv, m_brv, m_ard, m_brd}); else passed++;
      tick();
    end
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    tick();
  endtask

  task automatic test_simultaneous();
    set_a(1, 1, 14'h1, 16'h1111);
    tick();
    set_a(0, 0, '0, '0);
    set_b(1, 1, 14'h2, 16'h2222);
    tick();
    set_a(1, 0, 14'h1, '0);
    set_b(1, 0, 14'h2, '0);
    @(negedge clock);
    checks++; if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL simul_first: got %b want 10", {a_gnt, b_gnt}); else passed++;
    tick();
    set_a(0, 0, '0, '0);
    @(negedge clock);
    checks++; if ({a_gnt, b_gnt, a_rvalid, a_rdata} !== {3'b011, 16'h1111})
      $display("FAIL simul_second: got %h want %h", {a_gnt, b_gnt, a_rvalid, a_rdata}, {3'b011, 16'h1111}); else passed++;
    tick();
    set_b(0, 0, '0, '0);
    @(negedge clock);
    checks++; if ({b_rvalid, b_rdata, a_rvalid, a_rdata} !== {1'b1, 16'h2222, 1'b0, 16'h1111})
      $display("FAIL simul_b_resp: got %h want %h", {b_rvalid, b_rdata, a_rvalid, a_rdata}, {1'b1, 16'h2222, 1'b0, 16'h1111}); else passed++;
    tick();
  endtask

  task automatic test_hold();
    set_a(1, 1, 14'h20, 16'h00AA);
    tick();
    set_a(0, 0, '0, '0);
    set_b(1, 1, 14'h21, 16'h5555);
    tick();
    set_b(0, 0, '0, '0);
    set_a(1, 0, 14'h20, '0);
    tick();
    set_a(0, 0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      set_b(1, 0, 14'h21, '0);
      @(negedge clock);
      checks++; if (a_rdata !== 16'h00AA) $display("FAIL hold_a[%0d]: got %h want 00aa", k, a_rdata); else passed++;
      if (k > 0) begin
        checks++; if ({b_rvalid, b_rdata} !== {1'b1, 16'h5555}) $display("FAIL hold_b[%0d]: got %h want %h", k, {b_rvalid, b_rdata}, {1'b1, 16'h5555}); else passed++;
      end
      tick();
    end
    set_b(0, 0, '0, '0);
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (!a_req || e_ag) set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      if (!b_req || e_bg) set_b($urandom_range(0, 1) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      @(negedge clock);
      model_eval();
      checks++; if ({a_gnt, b_gnt, ram_load, ram_addr, ram_in} !== {e_ag, e_bg, e_ld, e_addr, e_in})
        $display("FAIL rand_drive[%0d]: got %h want %h", k, {a_gnt, b_gnt, ram_load, ram_addr, ram_in}, {e_ag, e_bg, e_ld, e_addr, e_in}); else passed++;
      checks++; if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== {m_arv, m_brv, m_ard, m_brd})
        $display("FAIL rand_resp[%0d]: got %h want %h", k, {a_rvalid, b_rvalid, a_rdata, b_rdata}, {m_arv, m_brv, m_ard, m_brd}); else passed++;
      tick();
    end
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    set_a(1, 0, 14'h10, '0);
    set_b(1, 0, 14'h30, '0);
    @(negedge clock);
    checks++; if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL mid_gnt: got %b want 10", {a_gnt, b_gnt}); else passed++;
    tick();
    checks++; if ({a_rvalid, dut.starve_cnt} !== {1'b1, 4'd1}) $display("FAIL mid_pre: got %h want %h", {a_rvalid, dut.starve_cnt}, {1'b1, 4'd1}); else passed++;
    reset_n = 1'b0;
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    model_reset();
    #1;
    checks++; if ({a_rvalid, b_rvalid, a_rdata, b_rdata, dut.starve_cnt} !== '0)
      $display("FAIL mid_reset: got %h want 0", {a_rvalid, b_rvalid, a_rdata, b_rdata, dut.starve_cnt}); else passed++;
    @(posedge clock);
    #1 reset_n = 1'b1;
    set_a(1, 0, 14'h10, '0);
    tick();
    set_a(0, 0, '0, '0);
    @(negedge clock);
    checks++; if ({a_rvalid, a_rdata} !== {1'b1, 16'h1234}) $display("FAIL mid_reissue: got %h want %h", {a_rvalid, a_rdata}, {1'b1, 16'h1234}); else passed++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = DW'($urandom);
      shadow[i] = ram[i];
    end
    ram_q = '0;
    test_reset();
    test_a_only();
    test_b_only();
    test_contention();
    test_simultaneous();
    test_hold();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
